// File: rtl/ice_risc_mem_pkg.sv
// Shared encodings and default widths for the ice_risc instruction/data memory arbiter.
package ice_risc_mem_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_STARVE_MAX = 4;

  // Latency counter must cover MEM_LAT-1 for MEM_LAT up to 7.
  localparam int LAT_W = 3;

  localparam logic ST_IDLE_ENC = 1'b0;
  localparam logic ST_WAIT_ENC = 1'b1;

  typedef enum logic {
    ST_IDLE = ST_IDLE_ENC,
    ST_WAIT = ST_WAIT_ENC
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  function automatic int starve_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ice_risc_mem_grant.sv
// Fetch/data grant selection with a saturating starvation counter that lets a waiting fetch win.
module ice_risc_mem_grant
  import ice_risc_mem_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int STARVE_W   = starve_width(STARVE_MAX)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic i_valid,
  input  logic d_valid,
  output logic gnt_fetch,
  output logic gnt_data
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_q;
  logic [STARVE_W-1:0] starve_d;
  logic                starve_hit;

  assign starve_hit = (starve_q == STARVE_LIM);

  // Grant decision and starvation counter update
  always_comb begin
    gnt_fetch = 1'b0;
    gnt_data  = 1'b0;
    starve_d  = starve_q;
    if (en) begin
      if (d_valid && !(i_valid && starve_hit)) begin
        gnt_data = 1'b1;
      end else if (i_valid) begin
        gnt_fetch = 1'b1;
      end else begin
        gnt_fetch = 1'b0;
      end
    end else begin
      gnt_data = 1'b0;
    end
    if (gnt_fetch) begin
      starve_d = '0;
    end else if (gnt_data && i_valid && !starve_hit) begin
      starve_d = starve_q + STARVE_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/ice_risc_mem_arbiter.sv
// Shares one single-port memory between the fetch and load/store ports, one access in flight at a time.
module ice_risc_mem_arbiter
  import ice_risc_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                wClk,
  input  logic                wnRst,
  input  logic                wIReqValid,
  input  logic [ADDR_W-1:0]   wIReqAddr,
  output logic                wIReqReady,
  output logic                wIRespValid,
  output logic [DATA_W-1:0]   wIRespData,
  input  logic                wDReqValid,
  input  logic                wDReqWe,
  input  logic [ADDR_W-1:0]   wDReqAddr,
  input  logic [DATA_W-1:0]   wDReqWdata,
  input  logic [DATA_W/8-1:0] wDReqWstrb,
  output logic                wDReqReady,
  output logic                wDRespValid,
  output logic [DATA_W-1:0]   wDRespData,
  output logic                wMemEn,
  output logic                wMemWe,
  output logic [ADDR_W-1:0]   wMemAddr,
  output logic [DATA_W-1:0]   wMemWdata,
  output logic [DATA_W/8-1:0] wMemWstrb,
  input  logic [DATA_W-1:0]   wMemRdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

  state_e              state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  owner_e              owner_q, owner_d;
  logic                we_q, we_d;
  logic                i_resp_valid_q, i_resp_valid_d;
  logic                d_resp_valid_q, d_resp_valid_d;
  logic [DATA_W-1:0]   i_resp_data_q, i_resp_data_d;
  logic [DATA_W-1:0]   d_resp_data_q, d_resp_data_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [STRB_W-1:0]   bus_wstrb_q, bus_wstrb_d;
  logic                grant_en;
  logic                gnt_fetch;
  logic                gnt_data;

  // Reset gates the grant so nothing is accepted while wnRst is low.
  assign grant_en = (state_q == ST_IDLE) && wnRst;

  ice_risc_mem_grant #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .clk       (wClk),
    .rst_n     (wnRst),
    .en        (grant_en),
    .i_valid   (wIReqValid),
    .d_valid   (wDReqValid),
    .gnt_fetch (gnt_fetch),
    .gnt_data  (gnt_data)
  );

  assign wIReqReady  = gnt_fetch;
  assign wDReqReady  = gnt_data;
  assign wMemEn      = gnt_fetch | gnt_data;
  assign wMemWe      = bus_we_d;
  assign wMemAddr    = bus_addr_d;
  assign wMemWdata   = bus_wdata_d;
  assign wMemWstrb   = bus_wstrb_d;
  assign wIRespValid = i_resp_valid_q;
  assign wIRespData  = i_resp_data_q;
  assign wDRespValid = d_resp_valid_q;
  assign wDRespData  = d_resp_data_q;

  // FSM next state, latency countdown, response capture and memory payload mux
  always_comb begin
    state_d        = state_q;
    lat_d          = lat_q;
    owner_d        = owner_q;
    we_d           = we_q;
    i_resp_valid_d = 1'b0;
    d_resp_valid_d = 1'b0;
    i_resp_data_d  = '0;
    d_resp_data_d  = '0;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_wdata_d    = bus_wdata_q;
    bus_wstrb_d    = bus_wstrb_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_data) begin
          state_d     = ST_WAIT;
          lat_d       = LAT_INIT;
          owner_d     = OWN_D;
          we_d        = wDReqWe;
          bus_we_d    = wDReqWe;
          bus_addr_d  = wDReqAddr;
          bus_wdata_d = wDReqWdata;
          bus_wstrb_d = wDReqWe ? wDReqWstrb : '0;
        end else if (gnt_fetch) begin
          state_d     = ST_WAIT;
          lat_d       = LAT_INIT;
          owner_d     = OWN_I;
          we_d        = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = wIReqAddr;
          bus_wstrb_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (lat_q == '0) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_I) begin
            i_resp_valid_d = 1'b1;
            i_resp_data_d  = wMemRdata;
          end else begin
            d_resp_valid_d = 1'b1;
            d_resp_data_d  = we_q ? '0 : wMemRdata;
          end
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        lat_d   = '0;
      end
    endcase
  end

  // State, response and held memory-bus registers
  always_ff @(posedge wClk) begin
    if (!wnRst) begin
      state_q        <= ST_IDLE;
      lat_q          <= '0;
      owner_q        <= OWN_I;
      we_q           <= 1'b0;
      i_resp_valid_q <= 1'b0;
      d_resp_valid_q <= 1'b0;
      i_resp_data_q  <= '0;
      d_resp_data_q  <= '0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= '0;
      bus_wdata_q    <= '0;
      bus_wstrb_q    <= '0;
    end else begin
      state_q        <= state_d;
      lat_q          <= lat_d;
      owner_q        <= owner_d;
      we_q           <= we_d;
      i_resp_valid_q <= i_resp_valid_d;
      d_resp_valid_q <= d_resp_valid_d;
      i_resp_data_q  <= i_resp_data_d;
      d_resp_data_q  <= d_resp_data_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_wdata_q    <= bus_wdata_d;
      bus_wstrb_q    <= bus_wstrb_d;
    end
  end

endmodule

// File: tb/tb_ice_risc_mem_arbiter.sv
// Directed bench for ice_risc_mem_arbiter with a two-cycle memory model (MEM_LAT=2, STARVE_MAX=4).
module tb_ice_risc_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_addr;
  logic        i_ready;
  logic        i_resp_valid;
  logic [31:0] i_resp_data;
  logic        d_valid;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ready;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic [31:0] mem_pipe;

  int n_vec;
  int n_err;

  ice_risc_mem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .MEM_LAT    (2),
    .STARVE_MAX (4)
  ) dut (
    .wClk        (clk),
    .wnRst       (rst_n),
    .wIReqValid  (i_valid),
    .wIReqAddr   (i_addr),
    .wIReqReady  (i_ready),
    .wIRespValid (i_resp_valid),
    .wIRespData  (i_resp_data),
    .wDReqValid  (d_valid),
    .wDReqWe     (d_we),
    .wDReqAddr   (d_addr),
    .wDReqWdata  (d_wdata),
    .wDReqWstrb  (d_wstrb),
    .wDReqReady  (d_ready),
    .wDRespValid (d_resp_valid),
    .wDRespData  (d_resp_data),
    .wMemEn      (mem_en),
    .wMemWe      (mem_we),
    .wMemAddr    (mem_addr),
    .wMemWdata   (mem_wdata),
    .wMemWstrb   (mem_wstrb),
    .wMemRdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    else return a ^ 32'hA5A5_0000;
  endfunction

  // Memory returns the word two cycles after the access strobe.
  always @(posedge clk) begin
    mem_pipe  <= mem_en ? mem_word(mem_addr) : 32'h0;
    mem_rdata <= mem_pipe;
  end

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_read(input logic [31:0] a, input logic [31:0] exp);
    i_valid = 1'b1;
    i_addr  = a;
    #1;
    check_vec("fr_ready", i_ready, 1'b1);
    check_vec("fr_memen", mem_en, 1'b1);
    check_vec("fr_addr", mem_addr, a);
    check_vec("fr_we", mem_we, 1'b0);
    cyc();
    i_valid = 1'b0;
    #1;
    check_vec("fr_t1_memen", mem_en, 1'b0);
    check_vec("fr_t1_resp", i_resp_valid, 1'b0);
    cyc();
    check_vec("fr_t2_resp", i_resp_valid, 1'b0);
    cyc();
    check_vec("fr_t3_resp", i_resp_valid, 1'b1);
    check_vec("fr_t3_data", i_resp_data, exp);
    check_vec("fr_t3_dresp", d_resp_valid, 1'b0);
    cyc();
    check_vec("fr_t4_resp", i_resp_valid, 1'b0);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    i_valid = 1'b1;
    i_addr  = 32'h0000_0040;
    d_valid = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h0000_0080;
    d_wdata = 32'h0;
    d_wstrb = 4'h0;

    // Reset held with both requesters valid, then D wins first and I follows.
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_vec("rst_iready", i_ready, 1'b0);
      check_vec("rst_dready", d_ready, 1'b0);
      check_vec("rst_memen", mem_en, 1'b0);
      check_vec("rst_iresp", {i_resp_valid, i_resp_data}, 33'h0);
      check_vec("rst_dresp", {d_resp_valid, d_resp_data}, 33'h0);
    end
    rst_n = 1'b1;
    #1;
    check_vec("post_rst_dready", d_ready, 1'b1);
    check_vec("post_rst_iready", i_ready, 1'b0);
    check_vec("post_rst_addr", mem_addr, 32'h0000_0080);
    check_vec("post_rst_wstrb", mem_wstrb, 4'h0);
    cyc();
    d_valid = 1'b0;
    #1;
    check_vec("wait_iready", i_ready, 1'b0);
    check_vec("wait_memen", mem_en, 1'b0);
    cyc();
    cyc();
    check_vec("cont_dresp", d_resp_valid, 1'b1);
    check_vec("cont_ddata", d_resp_data, 32'hA5A5_0080);
    check_vec("cont_iready", i_ready, 1'b1);
    check_vec("cont_iaddr", mem_addr, 32'h0000_0040);
    check_vec("cont_starve1", dut.u_grant.starve_q, 3'd1);
    cyc();
    i_valid = 1'b0;
    check_vec("cont_starve0", dut.u_grant.starve_q, 3'd0);
    check_vec("cont_dresp_off", d_resp_valid, 1'b0);
    cyc();
    cyc();
    check_vec("cont_iresp", i_resp_valid, 1'b1);
    check_vec("cont_idata", i_resp_data, 32'hA5A5_0040);
    cyc();

    // Single fetch read.
    fetch_read(32'h0000_0100, 32'hDEAD_BEEF);

    // Starvation: four D grants while I waits, then I is forced through.
    i_valid = 1'b1;
    i_addr  = 32'h0000_0300;
    d_valid = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h0000_0400;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_vec("stv_dready", d_ready, 1'b1);
      check_vec("stv_iready", i_ready, 1'b0);
      check_vec("stv_count", dut.u_grant.starve_q, 3'(k));
      cyc();
      cyc();
      cyc();
      check_vec("stv_dresp", d_resp_valid, 1'b1);
      check_vec("stv_ddata", d_resp_data, 32'hA5A5_0400);
    end
    check_vec("stv_force_i", i_ready, 1'b1);
    check_vec("stv_force_d", d_ready, 1'b0);
    check_vec("stv_force_addr", mem_addr, 32'h0000_0300);
    cyc();
    i_valid = 1'b0;
    check_vec("stv_clear", dut.u_grant.starve_q, 3'd0);
    cyc();
    cyc();
    check_vec("stv_iresp", i_resp_valid, 1'b1);
    check_vec("stv_idata", i_resp_data, 32'hA5A5_0300);
    check_vec("stv_d_again", d_ready, 1'b1);
    cyc();
    d_valid = 1'b0;
    cyc();
    cyc();
    cyc();

    // Store with partial strobes, then a store with no strobes.
    d_valid = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h0000_0200;
    d_wdata = 32'h1234_5678;
    d_wstrb = 4'b0011;
    #1;
    check_vec("st_memen", mem_en, 1'b1);
    check_vec("st_payload", {mem_we, mem_addr, mem_wdata, mem_wstrb}, {1'b1, 32'h0000_0200, 32'h1234_5678, 4'b0011});
    cyc();
    d_valid = 1'b0;
    #1;
    check_vec("st_t1_memen", mem_en, 1'b0);
    check_vec("st_held_addr", mem_addr, 32'h0000_0200);
    cyc();
    check_vec("st_t2_dresp", d_resp_valid, 1'b0);
    cyc();
    check_vec("st_ack", {d_resp_valid, d_resp_data}, {1'b1, 32'h0});
    check_vec("st_no_iresp", i_resp_valid, 1'b0);
    cyc();
    check_vec("st_ack_off", d_resp_valid, 1'b0);
    d_valid = 1'b1;
    d_addr  = 32'h0000_0204;
    d_wdata = 32'hCAFE_F00D;
    d_wstrb = 4'b0000;
    #1;
    check_vec("st0_memen", mem_en, 1'b1);
    check_vec("st0_wstrb", {mem_we, mem_wstrb}, {1'b1, 4'b0000});
    cyc();
    d_valid = 1'b0;
    cyc();
    cyc();
    check_vec("st0_ack", {d_resp_valid, d_resp_data}, {1'b1, 32'h0});
    cyc();

    // Reset during an in-flight load: its response never appears.
    d_valid = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h0000_0500;
    #1;
    check_vec("rm_dready", d_ready, 1'b1);
    cyc();
    d_valid = 1'b0;
    rst_n   = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_vec("rm_no_dresp", d_resp_valid, 1'b0);
      check_vec("rm_no_iresp", i_resp_valid, 1'b0);
      cyc();
    end
    fetch_read(32'h0000_0100, 32'hDEAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
